bfs_axi_read_arbiter: RTL and testbench

- Shares one single-beat AXI read master (AR/R channels) between two requesters:
  - port 0: main execution engine fetch path.
  - port 1: lookahead stats engine degree reads.
- Round-robin arbitration on AR.
- The memory side returns responses in request order. An in-order owner FIFO routes each R beat back to the requester that issued it.
- Sits between both engines and the PS HP port interconnect.

---
 rtl/bfs_axi_defs_pkg.sv | 19 +
 rtl/bfs_owner_fifo.sv | 57 +++++
 rtl/bfs_axi_read_arbiter.sv | 145 ++++++++++++++
 tb/tb_bfs_axi_read_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfs_axi_defs_pkg.sv
// rtl/bfs_axi_defs_pkg.sv - shared AXI width defaults and requester IDs for the read arbiter
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package bfs_axi_defs_pkg;

  localparam int unsigned DEF_ADDR_W = `AXI_ADDR_WIDTH;
  localparam int unsigned DEF_DATA_W = `AXI_DATA_WIDTH;

  typedef enum logic {
    REQ_EXEC = 1'b0,
    REQ_LSE  = 1'b1
  } req_id_e;

endpackage

// File: rtl/bfs_owner_fifo.sv
// rtl/bfs_owner_fifo.sv - in-order FIFO of requester IDs, one entry per AR granted but not yet answered
module bfs_owner_fifo
  import bfs_axi_defs_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  req_id_e                push_id,
  input  logic                   pop,
  output req_id_e                head_id,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  req_id_e          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head_id = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/bfs_axi_read_arbiter.sv
// rtl/bfs_axi_read_arbiter.sv - round-robin sharing of one single-beat AXI read master between two engines
// Optional perf counters (grant_cnt0/1, stall_cnt) under BFS_ARB_PERF_CNT_EN.
module bfs_axi_read_arbiter
  import bfs_axi_defs_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = DEF_ADDR_W,
  parameter int unsigned AXI_DATA_WIDTH  = DEF_DATA_W,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [AXI_ADDR_WIDTH-1:0]        s0_araddr,
  input  logic                             s0_arvalid,
  output logic                             s0_arready,
  output logic [AXI_DATA_WIDTH-1:0]        s0_rdata,
  output logic                             s0_rvalid,
  input  logic                             s0_rready,
  input  logic [AXI_ADDR_WIDTH-1:0]        s1_araddr,
  input  logic                             s1_arvalid,
  output logic                             s1_arready,
  output logic [AXI_DATA_WIDTH-1:0]        s1_rdata,
  output logic                             s1_rvalid,
  input  logic                             s1_rready,
  output logic [AXI_ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready,
`ifdef BFS_ARB_PERF_CNT_EN
  output logic [31:0]                      grant_cnt0,
  output logic [31:0]                      grant_cnt1,
  output logic [31:0]                      stall_cnt,
`endif
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_cnt,
  output logic                             rsp_orphan_err
);

  logic                      arvalid_q, arvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  req_id_e                   prio_q, prio_d;
  logic                      orphan_q, orphan_d;

  logic    slot_free, grant_ok, grant;
  req_id_e winner;
  logic    fifo_full, fifo_empty, rsp_pop;
  req_id_e head_id;

  // prio_q names the requester that wins a tie, i.e. the one not granted last.
  always_comb begin
    slot_free  = !arvalid_q || m_axi_arready;
    grant_ok   = slot_free && !fifo_full;
    winner     = REQ_EXEC;
    if (s0_arvalid && s1_arvalid) winner = prio_q;
    else if (s1_arvalid)          winner = REQ_LSE;
    s0_arready = grant_ok && s0_arvalid && (winner == REQ_EXEC);
    s1_arready = grant_ok && s1_arvalid && (winner == REQ_LSE);
    grant      = (s0_arvalid && s0_arready) || (s1_arvalid && s1_arready);
  end

  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    prio_d    = prio_q;
    if (grant) begin
      arvalid_d = 1'b1;
      araddr_d  = (winner == REQ_LSE) ? s1_araddr : s0_araddr;
      prio_d    = (winner == REQ_LSE) ? REQ_EXEC : REQ_LSE;
    end else if (m_axi_arready) begin
      arvalid_d = 1'b0;
    end
  end

  // Responses come back in issue order, so the FIFO head owns the current R beat.
  always_comb begin
    s0_rvalid    = m_axi_rvalid && !fifo_empty && (head_id == REQ_EXEC);
    s1_rvalid    = m_axi_rvalid && !fifo_empty && (head_id == REQ_LSE);
    m_axi_rready = !fifo_empty && ((head_id == REQ_EXEC) ? s0_rready : s1_rready);
    rsp_pop      = m_axi_rvalid && m_axi_rready;
    orphan_d     = orphan_q || (m_axi_rvalid && fifo_empty);
  end

  assign s0_rdata       = m_axi_rdata;
  assign s1_rdata       = m_axi_rdata;
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arvalid  = arvalid_q;
  assign rsp_orphan_err = orphan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      prio_q    <= REQ_EXEC;
      orphan_q  <= 1'b0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      prio_q    <= prio_d;
      orphan_q  <= orphan_d;
    end
  end

  bfs_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (grant),
    .push_id(winner),
    .pop    (rsp_pop),
    .head_id(head_id),
    .count  (outstanding_cnt),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

`ifdef BFS_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt0_q, grant_cnt0_d;
  logic [31:0] grant_cnt1_q, grant_cnt1_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt0_d = grant_cnt0_q + 32'(s0_arvalid && s0_arready);
    grant_cnt1_d = grant_cnt1_q + 32'(s1_arvalid && s1_arready);
    stall_cnt_d  = stall_cnt_q + 32'((s0_arvalid || s1_arvalid) && !grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bfs_axi_read_arbiter.sv
// tb/tb_bfs_axi_read_arbiter.sv - directed and random checks of the read arbiter against a queue-based model
module tb_bfs_axi_read_arbiter;

  localparam int MAXO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s0_araddr = '0, s1_araddr = '0;
  logic        s0_arvalid = 1'b0, s1_arvalid = 1'b0;
  logic        s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata;
  logic        s0_rvalid, s1_rvalid;
  logic        s0_rready = 1'b0, s1_rready = 1'b0;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [3:0]  outstanding_cnt;
  logic        rsp_orphan_err;
`ifdef BFS_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  always #5 clk = ~clk;

  bfs_axi_read_arbiter #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
`ifdef BFS_ARB_PERF_CNT_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt),
`endif
    .outstanding_cnt(outstanding_cnt), .rsp_orphan_err(rsp_orphan_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: pending AR register, owner queue, tie-break preference, sticky orphan flag.
  bit          m_arv;
  logic [31:0] m_ara;
  int          own_q[$];
  int          prio;
  bit          orphan;
  logic [31:0] mem_q[$];
  logic [31:0] req_q0[$], req_q1[$];
  logic [31:0] mem [logic [31:0]];
  bit          hs0, hs1;

  bit          ob_hs0, ob_hs1, ob_rv0, ob_rv1, ob_mrr;
  logic [31:0] ob_rd0, ob_rd1;
  int          dut_grants[$];
  logic [32:0] rlog[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic model_reset();
    m_arv = 1'b0; m_ara = '0; prio = 0; orphan = 1'b0;
    own_q.delete(); mem_q.delete(); req_q0.delete(); req_q1.delete();
    hs0 = 1'b0; hs1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step();
    bit gok, g0, g1, rv0, rv1, mrr, empty;
    int win;
    m_axi_rdata = (mem_q.size() > 0) ? mem_rd(mem_q[0]) : $urandom;
    @(negedge clk);
    empty = (own_q.size() == 0);
    gok   = (!m_arv || m_axi_arready) && (own_q.size() < MAXO);
    if (s0_arvalid && s1_arvalid) win = prio;
    else if (s0_arvalid)          win = 0;
    else if (s1_arvalid)          win = 1;
    else                          win = -1;
    g0  = gok && (win == 0);
    g1  = gok && (win == 1);
    rv0 = !empty && (own_q[0] == 0) && m_axi_rvalid;
    rv1 = !empty && (own_q[0] == 1) && m_axi_rvalid;
    mrr = !empty && ((own_q[0] == 0) ? s0_rready : s1_rready);

    expect_eq("s0_arready", 64'(s0_arready), 64'(g0));
    expect_eq("s1_arready", 64'(s1_arready), 64'(g1));
    expect_eq("m_arvalid", 64'(m_axi_arvalid), 64'(m_arv));
    expect_eq("m_araddr", 64'(m_axi_araddr), 64'(m_ara));
    expect_eq("s0_rvalid", 64'(s0_rvalid), 64'(rv0));
    expect_eq("s1_rvalid", 64'(s1_rvalid), 64'(rv1));
    expect_eq("m_rready", 64'(m_axi_rready), 64'(mrr));
    expect_eq("outstanding", 64'(outstanding_cnt), 64'(own_q.size()));
    expect_eq("orphan", 64'(rsp_orphan_err), 64'(orphan));
    if (rv0 && s0_rready && req_q0.size() > 0) expect_eq("s0_rdata", 64'(s0_rdata), 64'(mem_rd(req_q0.pop_front())));
    if (rv1 && s1_rready && req_q1.size() > 0) expect_eq("s1_rdata", 64'(s1_rdata), 64'(mem_rd(req_q1.pop_front())));

    ob_hs0 = s0_arvalid && s0_arready;
    ob_hs1 = s1_arvalid && s1_arready;
    ob_rv0 = s0_rvalid; ob_rv1 = s1_rvalid; ob_mrr = m_axi_rready;
    ob_rd0 = s0_rdata;  ob_rd1 = s1_rdata;
    if (ob_hs0) dut_grants.push_back(0);
    if (ob_hs1) dut_grants.push_back(1);
    if (s0_rvalid && s0_rready) rlog.push_back({1'b0, s0_rdata});
    if (s1_rvalid && s1_rready) rlog.push_back({1'b1, s1_rdata});

    if (m_axi_rvalid && empty) orphan = 1'b1;
    if (m_axi_rvalid && mrr) begin
      void'(own_q.pop_front());
      if (mem_q.size() > 0) void'(mem_q.pop_front());
    end
    if (m_arv && m_axi_arready) mem_q.push_back(m_ara);
    if (g0 || g1) begin
      own_q.push_back(win);
      m_arv = 1'b1;
      m_ara = g1 ? s1_araddr : s0_araddr;
      if (g1) req_q1.push_back(s1_araddr);
      else    req_q0.push_back(s0_araddr);
      prio = 1 - win;
    end else if (m_axi_arready) begin
      m_arv = 1'b0;
    end
    hs0 = g0; hs1 = g1;
    @(posedge clk); #1;
  endtask

  initial begin
    int g0n, g1n, ngr;
    int p_v0, p_v1, p_r, p_a, p_m;
    logic [31:0] held;

    do_reset();
    expect_eq("rst_outstanding", 64'(outstanding_cnt), 64'd0);
    expect_eq("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    expect_eq("rst_araddr", 64'(m_axi_araddr), 64'd0);
    expect_eq("rst_orphan", 64'(rsp_orphan_err), 64'd0);

    // Single request from s1
    mem[32'h1000] = 32'h2A;
    s1_arvalid = 1'b1; s1_araddr = 32'h1000; m_axi_arready = 1'b1;
    s0_rready = 1'b1; s1_rready = 1'b1;
    step();
    expect_eq("single_hs", 64'(ob_hs1), 64'd1);
    s1_arvalid = 1'b0;
    expect_eq("single_arvalid_lat", 64'(m_axi_arvalid), 64'd1);
    expect_eq("single_araddr", 64'(m_axi_araddr), 64'h1000);
    step(); step();
    m_axi_rvalid = 1'b1;
    step();
    m_axi_rvalid = 1'b0;
    expect_eq("single_s1_rvalid", 64'(ob_rv1), 64'd1);
    expect_eq("single_s1_rdata", 64'(ob_rd1), 64'h2A);
    expect_eq("single_s0_rvalid", 64'(ob_rv0), 64'd0);

    // Contention: alternating grants and responses routed back in order
    do_reset();
    for (int k = 0; k < 6; k++) mem[32'h100 * k] = 32'hA + k;
    dut_grants.delete(); rlog.delete();
    g0n = 0; g1n = 0; m_axi_arready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      s0_arvalid = (g0n < 3); s0_araddr = 32'h200 * g0n;
      s1_arvalid = (g1n < 3); s1_araddr = 32'h200 * g1n + 32'h100;
      step();
      if (hs0) g0n++;
      if (hs1) g1n++;
    end
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    expect_eq("cont_grants", 64'(dut_grants.size()), 64'd6);
    for (int k = 0; k < 6 && k < dut_grants.size(); k++)
      expect_eq("cont_order", 64'(dut_grants[k]), 64'(k % 2));
    s0_rready = 1'b1; s1_rready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      m_axi_rvalid = (mem_q.size() > 0);
      step();
    end
    m_axi_rvalid = 1'b0;
    expect_eq("cont_rbeats", 64'(rlog.size()), 64'd6);
    for (int k = 0; k < 6 && k < rlog.size(); k++)
      expect_eq("cont_route", 64'(rlog[k]), (64'(k % 2) << 32) | 64'(10 + k));

    // Owner FIFO full
    do_reset();
    s0_arvalid = 1'b1; s0_araddr = $urandom; m_axi_arready = 1'b1;
    ngr = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (ob_hs0) begin ngr++; s0_araddr = $urandom; end
    end
    expect_eq("full_accepted", 64'(ngr), 64'd8);
    expect_eq("full_outstanding", 64'(outstanding_cnt), 64'd8);
    expect_eq("full_arready", 64'(s0_arready), 64'd0);
    m_axi_rvalid = 1'b1; s0_rready = 1'b1;
    step();
    m_axi_rvalid = 1'b0;
    #1;
    expect_eq("full_slot_freed", 64'(s0_arready), 64'd1);
    expect_eq("full_after_pop", 64'(outstanding_cnt), 64'd7);
    step();
    expect_eq("full_refilled", 64'(outstanding_cnt), 64'd8);

    // AR backpressure, then R backpressure from head owner s0
    do_reset();
    s0_arvalid = 1'b1; s0_araddr = 32'h5000;
    step();
    s0_arvalid = 1'b0; s1_arvalid = 1'b1; s1_araddr = 32'h6000;
    held = m_axi_araddr;
    for (int c = 0; c < 5; c++) begin
      step();
      expect_eq("arbp_arvalid", 64'(m_axi_arvalid), 64'd1);
      expect_eq("arbp_araddr", 64'(m_axi_araddr), 64'(held));
      expect_eq("arbp_no_grant", 64'(ob_hs1), 64'd0);
    end
    m_axi_arready = 1'b1;
    step();
    expect_eq("arbp_release", 64'(ob_hs1), 64'd1);
    s1_arvalid = 1'b0;
    step();
    m_axi_rvalid = 1'b1; s0_rready = 1'b0; s1_rready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      expect_eq("rbp_m_rready", 64'(ob_mrr), 64'd0);
      expect_eq("rbp_s1_blocked", 64'(ob_rv1), 64'd0);
    end
    s0_rready = 1'b1;
    step();
    expect_eq("rbp_s0_rvalid", 64'(ob_rv0), 64'd1);
    step();
    expect_eq("rbp_s1_rvalid", 64'(ob_rv1), 64'd1);
    m_axi_rvalid = 1'b0;

    // Orphan response
    do_reset();
    m_axi_rvalid = 1'b1;
    step();
    m_axi_rvalid = 1'b0;
    expect_eq("orphan_rready", 64'(ob_mrr), 64'd0);
    expect_eq("orphan_set", 64'(rsp_orphan_err), 64'd1);
    step();
    expect_eq("orphan_sticky", 64'(rsp_orphan_err), 64'd1);

    // Reset with reads in flight
    do_reset();
    s0_arvalid = 1'b1; s0_araddr = $urandom; m_axi_arready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (hs0) s0_araddr = $urandom;
    end
    expect_eq("mid_outstanding", 64'(outstanding_cnt), 64'd3);
    do_reset();
    expect_eq("mid_rst_cnt", 64'(outstanding_cnt), 64'd0);
    expect_eq("mid_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    s0_arvalid = 1'b1; s1_arvalid = 1'b1;
    #1;
    expect_eq("mid_rst_ptr_s0", 64'(s0_arready), 64'd1);
    expect_eq("mid_rst_ptr_s1", 64'(s1_arready), 64'd0);
    step();

    // Randomized traffic
    p_v0 = 50; p_v1 = 50; p_r = 70; p_a = 70; p_m = 60;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) begin
        p_v0 = $urandom_range(5, 95); p_v1 = $urandom_range(5, 95);
        p_r  = $urandom_range(5, 100); p_a = $urandom_range(5, 100);
        p_m  = $urandom_range(5, 100);
      end
      if (c == 1700) do_reset();
      if (!s0_arvalid || hs0) begin
        s0_arvalid = ($urandom_range(0, 99) < p_v0); s0_araddr = $urandom;
      end
      if (!s1_arvalid || hs1) begin
        s1_arvalid = ($urandom_range(0, 99) < p_v1); s1_araddr = $urandom;
      end
      s0_rready     = ($urandom_range(0, 99) < p_r);
      s1_rready     = ($urandom_range(0, 99) < p_r);
      m_axi_arready = ($urandom_range(0, 99) < p_a);
      m_axi_rvalid  = (mem_q.size() > 0) && ($urandom_range(0, 99) < p_m);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
